// File: rtl/sqrt_check_bl.sv
// sqrt_check_bl
//   Sequential self-check for the square-root datapath. It squares the
//   candidate root SQRT with an iterative shift-add multiplier. It then reports
//   the following results:
//     SQ   : the square
//     REM  : the remainder BIN - SQ
//     GOOD : set when SQRT == floor(sqrt(BIN))
//   The handshake uses one-cycle pulses, the same as the square-root block.
//
// Ports
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   st    in   start pulse; accepted only while idle
//   BIN   in   W-bit radicand
//   SQRT  in   W-bit candidate root (only the low RW bits are squared)
//   ok    out  one-cycle done pulse
//   busy  out  high from the accepted st until ok
//   SQ    out  2*RW-bit square of SQRT[RW-1:0]
//   REM   out  BIN - SQ when SQ <= BIN, else 0
//   GOOD  out  SQRT is floor(sqrt(BIN))
//   OVF   out  SQRT has bits set above RW-1
module sqrt_check_bl #(
    parameter int W  = 27,
    parameter int RW = 14
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            st,
    input  logic [W-1:0]    BIN,
    input  logic [W-1:0]    SQRT,
    output logic            ok,
    output logic            busy,
    output logic [2*RW-1:0] SQ,
    output logic [W-1:0]    REM,
    output logic            GOOD,
    output logic            OVF
);

    localparam int CW = (RW > 1) ? $clog2(RW) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] CMP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]      state;
    logic [W-1:0]    b_r;
    logic [RW-1:0]   a_r;
    logic [RW-1:0]   m_r;
    logic [2*RW-1:0] acc;
    logic [CW-1:0]   cnt;
    logic            ovf_r;

    // The partial product is the root shifted by the current bit position.
    // The accumulator is sized to hold the full square, so no carry is lost.
    logic [2*RW-1:0] pp;
    assign pp = {{RW{1'b0}}, a_r} << cnt;

    // Compare the square against the radicand with both operands zero-extended
    // to a common width. This works whichever of W and 2*RW is larger.
    logic acc_gt;
    assign acc_gt = ({{(2*RW){1'b0}}, b_r} < {{W{1'b0}}, acc});

    // Only used when acc <= b_r, so the W-bit difference is exact.
    logic [W-1:0] rem_w;
    assign rem_w = b_r - acc[W-1:0];

    // SQRT is the floor root iff BIN < (SQRT+1)^2, i.e. REM <= 2*SQRT.
    // The comparison is done W+1 bits wide, so 2*a_r cannot wrap.
    logic good_w;
    assign good_w = ({1'b0, rem_w} <= ((W+1)'(a_r) << 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            b_r   <= '0;
            a_r   <= '0;
            m_r   <= '0;
            acc   <= '0;
            cnt   <= '0;
            ovf_r <= 1'b0;
            ok    <= 1'b0;
            busy  <= 1'b0;
            SQ    <= '0;
            REM   <= '0;
            GOOD  <= 1'b0;
            OVF   <= 1'b0;
        end else begin
            ok <= 1'b0;
            case (state)
                IDLE: begin
                    if (st) begin
                        b_r   <= BIN;
                        a_r   <= SQRT[RW-1:0];
                        m_r   <= SQRT[RW-1:0];
                        ovf_r <= |SQRT[W-1:RW];
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= MUL;
                    end
                end
                MUL: begin
                    if (m_r[0])
                        acc <= acc + pp;
                    m_r <= m_r >> 1;
                    cnt <= cnt + 1'b1;
                    // The multiplier always runs RW steps, so the latency
                    // does not depend on the data.
                    if (cnt == CW'(RW-1))
                        state <= CMP;
                end
                CMP: begin
                    SQ  <= acc;
                    OVF <= ovf_r;
                    if (ovf_r || acc_gt) begin
                        REM  <= '0;
                        GOOD <= 1'b0;
                    end else begin
                        REM  <= rem_w;
                        GOOD <= good_w;
                    end
                    state <= DONE;
                end
                DONE: begin
                    ok    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_check_bl.sv
module tb_sqrt_check_bl;

    logic        clk;
    logic        rst;
    logic        st;
    logic [26:0] BIN;
    logic [26:0] SQRT;
    logic        ok;
    logic        busy;
    logic [27:0] SQ;
    logic [26:0] REM;
    logic        GOOD;
    logic        OVF;

    int n_checks;
    int n_fail;

    sqrt_check_bl #(.W(27), .RW(14)) dut (
        .clk (clk),
        .rst (rst),
        .st  (st),
        .BIN (BIN),
        .SQRT(SQRT),
        .ok  (ok),
        .busy(busy),
        .SQ  (SQ),
        .REM (REM),
        .GOOD(GOOD),
        .OVF (OVF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the squared low 14 bits.
    function automatic void model(input longint bin, input longint sqrt,
                                  output longint sq, output longint rem,
                                  output bit good, output bit ovf);
        longint r;
        ovf = (sqrt >= 16384);
        r   = sqrt % 16384;
        sq  = r * r;
        if (ovf || sq > bin) begin
            rem  = 0;
            good = 1'b0;
        end else begin
            rem  = bin - sq;
            good = ((r + 1) * (r + 1) > bin);
        end
    endfunction

    function automatic longint isqrt(input longint v);
        longint r;
        r = longint'($sqrt(real'(v)));
        while (r * r > v) r--;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Drives one operation and observes it for 24 cycles after acceptance.
    // st2_at > 0 sends a second start pulse that many cycles in.
    task automatic do_op(input logic [26:0] bin, input logic [26:0] sqrt_in,
                         input int st2_at, output int lat, output int nok,
                         output int nbusy);
        @(negedge clk);
        BIN = bin; SQRT = sqrt_in; st = 1'b1;
        @(posedge clk); #1;
        st = 1'b0;
        BIN = 27'($urandom); SQRT = 27'($urandom);
        lat = 0; nok = 0;
        nbusy = busy ? 1 : 0;
        for (int k = 1; k <= 24; k++) begin
            if (k == st2_at) begin
                st = 1'b1; BIN = 27'($urandom); SQRT = 27'($urandom);
            end
            @(posedge clk); #1;
            st = 1'b0;
            if (ok) begin
                nok++;
                if (lat == 0) lat = k;
            end
            if (busy) nbusy++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; st = 1'b0; BIN = '0; SQRT = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({ok, busy, SQ, REM, GOOD, OVF} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got ok=%b busy=%b SQ=%0d REM=%0d GOOD=%b OVF=%b, need all 0",
                     ok, busy, SQ, REM, GOOD, OVF);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [26:0] tb_bin  [9] = '{100, 120, 121, 99, 99999999, 99999999, 5,     0, 255};
        logic [26:0] tb_sqrt [9] = '{10,  10,  10,  10, 9999,     16383,    16384, 0, 0};
        longint esq, erem;
        bit egood, eovf;
        int lat, nok, nbusy;
        for (int i = 0; i < 9; i++) begin
            do_op(tb_bin[i], tb_sqrt[i], 0, lat, nok, nbusy);
            model(tb_bin[i], tb_sqrt[i], esq, erem, egood, eovf);
            n_checks++;
            if (lat != 16 || nok != 1 || nbusy != 16) begin
                n_fail++;
                $display("FAIL dir_handshake[%0d]: got lat=%0d oks=%0d busy_cycles=%0d, need 16/1/16",
                         i, lat, nok, nbusy);
            end
            n_checks++;
            if (SQ !== 28'(esq) || REM !== 27'(erem) || GOOD !== egood || OVF !== eovf) begin
                n_fail++;
                $display("FAIL dir_result[%0d] BIN=%0d SQRT=%0d: got SQ=%0d REM=%0d GOOD=%b OVF=%b, need SQ=%0d REM=%0d GOOD=%b OVF=%b",
                         i, tb_bin[i], tb_sqrt[i], SQ, REM, GOOD, OVF, esq, erem, egood, eovf);
            end
        end
    endtask

    task automatic test_random();
        longint esq, erem, r;
        bit egood, eovf;
        int lat, nok, nbusy, sel;
        logic [26:0] b, s;
        for (int i = 0; i < 40; i++) begin
            b   = 27'($urandom);
            sel = int'($urandom_range(0, 4));
            r   = isqrt(b);
            case (sel)
                0: s = 27'(r);
                1: s = 27'(r + 1);
                2: s = (r > 0) ? 27'(r - 1) : 27'(0);
                3: s = 27'($urandom_range(0, 16383));
                default: s = 27'($urandom);
            endcase
            do_op(b, s, 0, lat, nok, nbusy);
            model(b, s, esq, erem, egood, eovf);
            n_checks++;
            if (lat != 16 || nok != 1 || SQ !== 28'(esq) || REM !== 27'(erem) ||
                GOOD !== egood || OVF !== eovf) begin
                n_fail++;
                $display("FAIL rand[%0d] BIN=%0d SQRT=%0d: got lat=%0d oks=%0d SQ=%0d REM=%0d GOOD=%b OVF=%b, need 16/1 SQ=%0d REM=%0d GOOD=%b OVF=%b",
                         i, b, s, lat, nok, SQ, REM, GOOD, OVF, esq, erem, egood, eovf);
            end
        end
    endtask

    task automatic test_back_to_back();
        longint esq, erem;
        bit egood, eovf;
        int lat, nok, nbusy;
        do_op(27'd150, 27'd12, 5, lat, nok, nbusy);
        model(150, 12, esq, erem, egood, eovf);
        n_checks++;
        if (lat != 16 || nok != 1) begin
            n_fail++;
            $display("FAIL st_while_busy_handshake: got lat=%0d oks=%0d, need 16/1", lat, nok);
        end
        n_checks++;
        if (SQ !== 28'(esq) || REM !== 27'(erem) || GOOD !== egood) begin
            n_fail++;
            $display("FAIL st_while_busy_result: got SQ=%0d REM=%0d GOOD=%b, need SQ=%0d REM=%0d GOOD=%b",
                     SQ, REM, GOOD, esq, erem, egood);
        end
    endtask

    task automatic test_reset_abort();
        longint esq, erem;
        bit egood, eovf;
        int lat, nok, nbusy, nok2;
        @(negedge clk);
        BIN = 27'd1000; SQRT = 27'd31; st = 1'b1;
        @(posedge clk); #1;
        st = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({ok, busy, SQ, REM, GOOD, OVF} !== '0) begin
            n_fail++;
            $display("FAIL abort_cleared: got ok=%b busy=%b SQ=%0d REM=%0d GOOD=%b OVF=%b, need all 0",
                     ok, busy, SQ, REM, GOOD, OVF);
        end
        nok2 = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (ok) nok2++;
        end
        n_checks++;
        if (nok2 != 0) begin
            n_fail++;
            $display("FAIL abort_no_ok: got %0d ok pulses, need 0", nok2);
        end
        do_op(27'd1000, 27'd31, 0, lat, nok, nbusy);
        model(1000, 31, esq, erem, egood, eovf);
        n_checks++;
        if (lat != 16 || nok != 1 || SQ !== 28'(esq) || REM !== 27'(erem) || GOOD !== egood) begin
            n_fail++;
            $display("FAIL after_abort: got lat=%0d oks=%0d SQ=%0d REM=%0d GOOD=%b, need 16/1 SQ=%0d REM=%0d GOOD=%b",
                     lat, nok, SQ, REM, GOOD, esq, erem, egood);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
